raster_dispatcher: RTL and testbench

- Initiator and consumer on the far side of the raymarcher pixel interface.
- Drives curr_x/curr_y in raster order.
- Accepts each finished pixel on the pixel_done strobe and checks its returned coordinates.
- Queues {address, RGB} into a small FIFO and writes it to the framebuffer BRAM write port, with frame-complete signalling.

---
 rtl/raster_pkg.sv | 22 ++
 rtl/raster_dispatcher_if.sv | 12 +
 rtl/raster_dispatcher_fb_write_fifo.sv | 53 +++++
 rtl/raster_dispatcher.sv | 121 ++++++++++++
 tb/tb_raster_dispatcher.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/raster_pkg.sv
// Shared types for the raster dispatcher: FSM state, framebuffer entry and RGB packing.
package raster_pkg;

    localparam int FB_ADDR_MAX_W = 24;
    localparam int RGB_W         = 24;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dispatcher_state_e;

    typedef struct packed {
        logic [FB_ADDR_MAX_W-1:0] addr;
        logic [RGB_W-1:0]         rgb;
    } fb_entry_t;

    function automatic logic [RGB_W-1:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                                  input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/raster_dispatcher_if.sv
// Framebuffer write port between the dispatcher (master) and the BRAM (slave).
interface raster_dispatcher_if #(parameter int ADDR_W = 20) ();
    // Handshake: a write happens on any rising edge where fb_we_out is high; the master
    // raises fb_we_out only while fb_ready_in is high, so fb_we_out alone marks the transfer.
    logic [ADDR_W-1:0] fb_addr_out;
    logic [23:0]       fb_data_out;
    logic              fb_we_out;
    logic              fb_ready_in;

    modport master (output fb_addr_out, fb_data_out, fb_we_out, input fb_ready_in);
    modport slave  (input fb_addr_out, fb_data_out, fb_we_out, output fb_ready_in);
endinterface

// File: rtl/raster_dispatcher_fb_write_fifo.sv
// Small synchronous FIFO; push and pop may coincide at any occupancy, head holds when empty.
module fb_write_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   cnt_q;
    logic [W-1:0]  last_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // last_q keeps the most recently popped entry visible once the FIFO drains
    assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/raster_dispatcher.sv
// Raster-order pixel dispatcher: hands coordinates to the raymarcher, checks returned
// coordinates and queues {address, RGB} results toward the framebuffer write port.
module raster_dispatcher
    import raster_pkg::*;
#(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int FIFO_DEPTH = 2,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int AW = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk_pixel_in,
    input  logic              rst_in,
    input  logic              enable_in,
    input  logic              pixel_done,
    input  logic [XW-1:0]     rm_out_x,
    input  logic [YW-1:0]     rm_out_y,
    input  logic [7:0]        red_in,
    input  logic [7:0]        green_in,
    input  logic [7:0]        blue_in,
    output logic [XW-1:0]     curr_x,
    output logic [YW-1:0]     curr_y,
    raster_dispatcher_if.master fb,
    output logic              frame_done_out,
    output logic [15:0]       frame_count_out,
    output logic              seq_error_out,
    output logic              overflow_out,
    output dispatcher_state_e state_dbg_o
);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    dispatcher_state_e state_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [AW-1:0]     addr_q;
    logic              frame_done_q, seq_err_q, ovf_q;
    logic [15:0]       frame_cnt_q;

    fb_entry_t push_entry, head_entry;
    logic      push, pop, fifo_full, fifo_empty, last_px;

    assign push    = (state_q == RUN) && pixel_done;
    assign pop     = fb.fb_ready_in;
    assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        push_entry      = '0;
        push_entry.addr = FB_ADDR_MAX_W'(addr_q);
        push_entry.rgb  = pack_rgb(red_in, green_in, blue_in);
    end

    fb_write_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(fb_entry_t))) u_fifo (
        .clk_i      (clk_pixel_in),
        .rst_ni     (rst_in),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (head_entry)
    );

    assign fb.fb_addr_out = head_entry.addr[AW-1:0];
    assign fb.fb_data_out = head_entry.rgb;
    assign fb.fb_we_out   = !fifo_empty && fb.fb_ready_in;

    if (AW < FB_ADDR_MAX_W) begin : g_addr_pad
        logic unused_addr_bits;
        assign unused_addr_bits = ^head_entry.addr[FB_ADDR_MAX_W-1:AW];
    end

    // Expected coordinate doubles as curr: the raymarcher samples it the cycle after pixel_done
    always_ff @(posedge clk_pixel_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            seq_err_q    <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (push && fifo_full && !pop) ovf_q <= 1'b1;
            case (state_q)
                IDLE: if (pixel_done && enable_in) state_q <= RUN;
                RUN: if (pixel_done) begin
                    if (rm_out_x != x_q || rm_out_y != y_q) seq_err_q <= 1'b1;
                    if (last_px) begin
                        x_q          <= '0;
                        y_q          <= '0;
                        addr_q       <= '0;
                        frame_done_q <= 1'b1;
                        frame_cnt_q  <= frame_cnt_q + 16'd1;
                        if (!enable_in) state_q <= IDLE;
                    end else begin
                        addr_q <= addr_q + AW'(1);
                        if (x_q == X_LAST) begin
                            x_q <= '0;
                            y_q <= y_q + YW'(1);
                        end else begin
                            x_q <= x_q + XW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign curr_x          = x_q;
    assign curr_y          = y_q;
    assign frame_done_out  = frame_done_q;
    assign frame_count_out = frame_cnt_q;
    assign seq_error_out   = seq_err_q;
    assign overflow_out    = ovf_q;
    assign state_dbg_o     = state_q;
endmodule

// File: tb/tb_raster_dispatcher.sv
// Directed bench for raster_dispatcher at 4x2 resolution with a 2-entry write FIFO.
module tb_raster_dispatcher;
    import raster_pkg::*;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int XW = 2;
    localparam int YW = 1;
    localparam int AW = 3;
    localparam int EW = AW + 24;

    logic              clk;
    logic              rst_in, enable_in, pixel_done;
    logic [XW-1:0]     rm_out_x;
    logic [YW-1:0]     rm_out_y;
    logic [7:0]        red_in, green_in, blue_in;
    logic [XW-1:0]     curr_x;
    logic [YW-1:0]     curr_y;
    logic              frame_done_out, seq_error_out, overflow_out;
    logic [15:0]       frame_count_out;
    dispatcher_state_e state_dbg;

    raster_dispatcher_if #(.ADDR_W(AW)) fb_bus ();

    raster_dispatcher #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(2)) dut (
        .clk_pixel_in   (clk),
        .rst_in         (rst_in),
        .enable_in      (enable_in),
        .pixel_done     (pixel_done),
        .rm_out_x       (rm_out_x),
        .rm_out_y       (rm_out_y),
        .red_in         (red_in),
        .green_in       (green_in),
        .blue_in        (blue_in),
        .curr_x         (curr_x),
        .curr_y         (curr_y),
        .fb             (fb_bus.master),
        .frame_done_out (frame_done_out),
        .frame_count_out(frame_count_out),
        .seq_error_out  (seq_error_out),
        .overflow_out   (overflow_out),
        .state_dbg_o    (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Driver tasks: all start and end at posedge+1
    task automatic strobe(input int x, input int y, input logic [23:0] rgb);
        rm_out_x   = XW'(x);
        rm_out_y   = YW'(y);
        red_in     = rgb[23:16];
        green_in   = rgb[15:8];
        blue_in    = rgb[7:0];
        pixel_done = 1'b1;
        @(posedge clk); #1;
        pixel_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_in     = 1'b0;
        pixel_done = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        rst_in = 1'b1;
    endtask

    task automatic expect_wr(input int a, input logic [23:0] rgb);
        exp_q.push_back({AW'(a), rgb});
    endtask

    // Scoreboard: each write strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_in && fb_bus.fb_we_out) begin
            n_writes++;
            if (exp_q.size() == 0) check("unexpected_write", {fb_bus.fb_addr_out, fb_bus.fb_data_out}, 32'hDEAD);
            else check("fb_write", {fb_bus.fb_addr_out, fb_bus.fb_data_out}, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, fb_bus.fb_we_out, 0);
        check({tag, "_addr"}, fb_bus.fb_addr_out, 0);
        check({tag, "_data"}, fb_bus.fb_data_out, 0);
        check({tag, "_cx"}, curr_x, 0);
        check({tag, "_cy"}, curr_y, 0);
        check({tag, "_fdone"}, frame_done_out, 0);
        check({tag, "_fcnt"}, frame_count_out, 0);
        check({tag, "_seq"}, seq_error_out, 0);
        check({tag, "_ovf"}, overflow_out, 0);
        check({tag, "_state"}, state_dbg, IDLE);
    endtask

    initial begin
        int w0;
        rst_in = 1'b0; enable_in = 1'b0; pixel_done = 1'b0;
        rm_out_x = '0; rm_out_y = '0; red_in = '0; green_in = '0; blue_in = '0;
        fb_bus.fb_ready_in = 1'b1;
        idle(2);
        check_all_zero("rst");
        rst_in = 1'b1;

        // Full frame in raster order
        enable_in = 1'b1;
        strobe(0, 0, 24'hFFFFFF);
        check("t1_state_run", state_dbg, RUN);
        for (int i = 0; i < 8; i++) begin
            expect_wr(i, 24'h010203 + 24'(i));
            strobe(i % 4, i / 4, 24'h010203 + 24'(i));
            check("t1_curr_x", curr_x, (i + 1) % 4);
            check("t1_curr_y", curr_y, ((i + 1) / 4) % 2);
            check("t1_frame_done", frame_done_out, i == 7);
        end
        check("t1_frame_count", frame_count_out, 1);
        idle(1);
        check("t1_frame_done_pulse", frame_done_out, 0);
        idle(3);
        check("t1_drain", exp_q.size(), 0);
        check("t1_writes", n_writes, 8);
        check("t1_seq", seq_error_out, 0);

        // Coordinate mismatch
        do_reset();
        strobe(0, 0, 24'h0);
        expect_wr(0, 24'hA00001);
        strobe(0, 0, 24'hA00001);
        check("t2_seq_before", seq_error_out, 0);
        expect_wr(1, 24'hA00002);
        strobe(2, 0, 24'hA00002);
        check("t2_seq_set", seq_error_out, 1);
        expect_wr(2, 24'hA00003);
        strobe(2, 0, 24'hA00003);
        idle(3);
        check("t2_seq_sticky", seq_error_out, 1);
        check("t2_drain", exp_q.size(), 0);

        // Overflow with the write port stalled
        do_reset();
        check("t3_seq_cleared", seq_error_out, 0);
        fb_bus.fb_ready_in = 1'b0;
        strobe(0, 0, 24'h0);
        expect_wr(0, 24'hB00000);
        strobe(0, 0, 24'hB00000);
        expect_wr(1, 24'hB00001);
        strobe(1, 0, 24'hB00001);
        check("t3_ovf_full", overflow_out, 0);
        strobe(2, 0, 24'hB00002);
        check("t3_ovf_set", overflow_out, 1);
        check("t3_curr_x", curr_x, 3);
        w0 = n_writes;
        fb_bus.fb_ready_in = 1'b1;
        idle(4);
        check("t3_two_writes", n_writes - w0, 2);
        expect_wr(3, 24'hB00003);
        strobe(3, 0, 24'hB00003);
        idle(3);
        check("t3_drain", exp_q.size(), 0);
        check("t3_ovf_sticky", overflow_out, 1);

        // Push and pop together while full
        do_reset();
        check("t4_ovf_cleared", overflow_out, 0);
        fb_bus.fb_ready_in = 1'b0;
        strobe(0, 0, 24'h0);
        expect_wr(0, 24'hC00000);
        strobe(0, 0, 24'hC00000);
        expect_wr(1, 24'hC00001);
        strobe(1, 0, 24'hC00001);
        fb_bus.fb_ready_in = 1'b1;
        expect_wr(2, 24'hC00002);
        strobe(2, 0, 24'hC00002);
        check("t4_no_ovf", overflow_out, 0);
        idle(4);
        check("t4_drain", exp_q.size(), 0);
        check("t4_hold_addr", fb_bus.fb_addr_out, 2);
        check("t4_hold_data", fb_bus.fb_data_out, 32'hC00002);

        // enable_in drops mid-frame
        do_reset();
        enable_in = 1'b1;
        strobe(0, 0, 24'h0);
        for (int i = 0; i < 8; i++) begin
            if (i == 5) enable_in = 1'b0;
            expect_wr(i, 24'hD00000 + 24'(i));
            strobe(i % 4, i / 4, 24'hD00000 + 24'(i));
        end
        check("t5_state_idle", state_dbg, IDLE);
        check("t5_frame_count", frame_count_out, 1);
        idle(3);
        check("t5_drain", exp_q.size(), 0);
        w0 = n_writes;
        strobe(0, 0, 24'hEEEEEE);
        strobe(1, 0, 24'hEEEEEE);
        idle(3);
        check("t5_no_writes_idle", n_writes - w0, 0);
        enable_in = 1'b1;
        strobe(0, 0, 24'hEEEEEE);
        check("t5_rearm_run", state_dbg, RUN);
        expect_wr(0, 24'hD10000);
        strobe(0, 0, 24'hD10000);
        idle(3);
        check("t5_rearm_drain", exp_q.size(), 0);

        // Reset mid-frame with two entries queued
        fb_bus.fb_ready_in = 1'b0;
        expect_wr(1, 24'hF00001);
        strobe(1, 0, 24'hF00001);
        expect_wr(2, 24'hF00002);
        strobe(2, 0, 24'hF00002);
        check("t6_queued", exp_q.size(), 2);
        do_reset();
        fb_bus.fb_ready_in = 1'b1;
        check_all_zero("t6_rst");
        strobe(0, 0, 24'h0);
        expect_wr(0, 24'hF10000);
        strobe(0, 0, 24'hF10000);
        check("t6_curr_x", curr_x, 1);
        idle(3);
        check("t6_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
